// File: rtl/mastermind_pkg.sv
// Shared widths, shape encoding and helpers for the Mastermind-style game.
package mastermind_pkg;

    localparam int unsigned SHAPE_W   = 3;
    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned PATTERN_W = SHAPE_W * NUM_SLOTS;
    localparam int unsigned ZNARLY_W  = 4;
    localparam int unsigned SLOT_IDX_W = 2;

    typedef enum logic [SHAPE_W-1:0] {
        BLANK    = 3'd0,
        TRIANGLE = 3'd1,
        CIRCLE   = 3'd2,
        DIAMOND  = 3'd3,
        ICECREAM = 3'd4,
        DOLLAR   = 3'd5,
        STAR     = 3'd6,
        INVALID  = 3'd7
    } shape_t;

    // A shape code is loadable unless it is the blank or the invalid marker.
    function automatic logic is_valid_shape(input logic [SHAPE_W-1:0] shape);
        return (shape != BLANK) && (shape != INVALID);
    endfunction

endpackage

// File: rtl/check_for_znarly.sv
// Counts exact slot matches between a guess and the master pattern (combinational).
module check_for_znarly
    import mastermind_pkg::*;
(
    input  logic [PATTERN_W-1:0] masterPattern,
    input  logic [PATTERN_W-1:0] Guess,
    output logic [ZNARLY_W-1:0]  Znarly
);

    // Sum of per-slot equality bits; all 3 bits compared, invalid codes included.
    always_comb begin
        Znarly = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            Znarly = Znarly + ZNARLY_W'(Guess[k*SHAPE_W +: SHAPE_W] ==
                                        masterPattern[k*SHAPE_W +: SHAPE_W]);
        end
    end

endmodule

// File: rtl/load_master_pattern.sv
// Stores the four-slot secret pattern, tracks which slots are filled and scores guesses.
module load_master_pattern
    import mastermind_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_L,
    input  logic [SHAPE_W-1:0]    LoadShape,
    input  logic [SLOT_IDX_W-1:0] ShapeLocation,
    input  logic                  loadingShape,
    input  logic                  startGame,
    input  logic [PATTERN_W-1:0]  Guess,
    output logic [PATTERN_W-1:0]  masterPattern,
    output logic                  masterLoaded,
    output logic [ZNARLY_W-1:0]   Znarly
);

    logic [PATTERN_W-1:0] r_pattern;
    logic [NUM_SLOTS-1:0] r_filled;
    logic                 r_loaded;
    logic [PATTERN_W-1:0] w_pattern_nxt;
    logic [NUM_SLOTS-1:0] w_filled_nxt;
    logic                 w_write_en;

    assign w_write_en = loadingShape && is_valid_shape(LoadShape);

    // Write decoder: clear has priority over a load; invalid shapes are dropped.
    always_comb begin
        w_pattern_nxt = r_pattern;
        w_filled_nxt  = r_filled;
        if (startGame) begin
            w_pattern_nxt = '0;
            w_filled_nxt  = '0;
        end else if (w_write_en) begin
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                if (ShapeLocation == SLOT_IDX_W'(k)) begin
                    w_pattern_nxt[k*SHAPE_W +: SHAPE_W] = LoadShape;
                    w_filled_nxt[k]                     = 1'b1;
                end
            end
        end
    end

    // Slot, filled and loaded registers; loaded is registered from the next filled set.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_pattern <= '0;
            r_filled  <= '0;
            r_loaded  <= 1'b0;
        end else begin
            r_pattern <= w_pattern_nxt;
            r_filled  <= w_filled_nxt;
            r_loaded  <= &w_filled_nxt;
        end
    end

    assign masterPattern = r_pattern;
    assign masterLoaded  = r_loaded;

    check_for_znarly u_check_for_znarly (
        .masterPattern (r_pattern),
        .Guess         (Guess),
        .Znarly        (Znarly)
    );

endmodule

// File: tb/tb_load_master_pattern.sv
// Scoreboard bench: stimulus pushes expected outputs, a monitor pops and compares.
module tb_load_master_pattern;

    logic        clock = 1'b0;
    logic        reset_L = 1'b0;
    logic [2:0]  LoadShape = '0;
    logic [1:0]  ShapeLocation = '0;
    logic        loadingShape = 1'b0;
    logic        startGame = 1'b0;
    logic [11:0] Guess = '0;
    logic [11:0] masterPattern;
    logic        masterLoaded;
    logic [3:0]  Znarly;

    typedef struct {
        logic [11:0] pat;
        logic        ld;
        logic [3:0]  zn;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    // Reference model: slot contents and filled flags as plain arrays.
    int   m_slot[4];
    bit   m_filled[4];

    load_master_pattern dut (
        .clock         (clock),
        .reset_L       (reset_L),
        .LoadShape     (LoadShape),
        .ShapeLocation (ShapeLocation),
        .loadingShape  (loadingShape),
        .startGame     (startGame),
        .Guess         (Guess),
        .masterPattern (masterPattern),
        .masterLoaded  (masterLoaded),
        .Znarly        (Znarly)
    );

    always #5 clock = ~clock;

    function automatic void model_clear();
        for (int k = 0; k < 4; k++) begin
            m_slot[k]   = 0;
            m_filled[k] = 1'b0;
        end
    endfunction

    function automatic logic [11:0] model_pattern();
        logic [11:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) p = p | (12'(m_slot[k]) << (3 * k));
        return p;
    endfunction

    function automatic exp_t model_exp(input logic [11:0] g);
        exp_t e;
        int   hits;
        int   gs;
        e.pat = model_pattern();
        e.ld  = m_filled[0] && m_filled[1] && m_filled[2] && m_filled[3];
        hits  = 0;
        for (int k = 0; k < 4; k++) begin
            gs = int'((g >> (3 * k)) & 12'h7);
            if (gs == m_slot[k]) hits++;
        end
        e.zn = 4'(hits);
        return e;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict the post-edge state.
    task automatic cycle(input logic rst, input logic [2:0] ls, input logic [1:0] loc,
                         input logic ld, input logic sg, input logic [11:0] g);
        @(negedge clock);
        reset_L       = rst;
        LoadShape     = ls;
        ShapeLocation = loc;
        loadingShape  = ld;
        startGame     = sg;
        Guess         = g;
        if (!rst || sg) begin
            model_clear();
        end else if (ld && ls != 3'd0 && ls != 3'd7) begin
            m_slot[loc]   = int'(ls);
            m_filled[loc] = 1'b1;
        end
        q.push_back(model_exp(g));
        mon_en = 1'b1;
    endtask

    // Assert reset in the middle of the high phase; outputs must clear at once.
    task automatic async_reset();
        @(posedge clock);
        #2;
        reset_L = 1'b0;
        model_clear();
        q.push_back(model_exp(Guess));
    endtask

    task automatic idle(input logic [11:0] g);
        cycle(1'b1, 3'd0, 2'd0, 1'b0, 1'b0, g);
    endtask

    // Monitor: compare once after each rising edge and on each reset assertion.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(posedge clock or negedge reset_L);
            #1;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = q.pop_front();
                checks++;
                if (masterPattern !== e.pat) begin
                    failures++;
                    $display("FAIL masterPattern t=%0t got=%03h exp=%03h", $time, masterPattern, e.pat);
                end
                checks++;
                if (masterLoaded !== e.ld) begin
                    failures++;
                    $display("FAIL masterLoaded t=%0t got=%0b exp=%0b", $time, masterLoaded, e.ld);
                end
                checks++;
                if (Znarly !== e.zn) begin
                    failures++;
                    $display("FAIL Znarly t=%0t guess=%03h got=%0d exp=%0d", $time, Guess, Znarly, e.zn);
                end
            end
        end
    end

    initial begin
        logic [11:0] g;
        logic [11:0] p;
        int          drained;
        model_clear();

        // Reset held, Guess 0 scores 4 against the cleared pattern
        cycle(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 12'h000);
        cycle(1'b0, 3'd1, 2'd0, 1'b1, 1'b0, 12'h000);
        // Release and single load
        idle(12'h000);
        cycle(1'b1, 3'b001, 2'd0, 1'b1, 1'b0, 12'h000);
        idle(12'h001);

        // Fill all slots
        cycle(1'b1, 3'b100, 2'd0, 1'b1, 1'b0, 12'h000);
        cycle(1'b1, 3'b011, 2'd1, 1'b1, 1'b0, 12'h000);
        cycle(1'b1, 3'b010, 2'd2, 1'b1, 1'b0, 12'h000);
        cycle(1'b1, 3'b001, 2'd3, 1'b1, 1'b0, 12'b001_010_011_100);

        // Znarly scoring table
        idle(12'b001_010_011_100);
        idle(12'b011_010_011_100);
        idle(12'b011_011_011_100);
        idle(12'b011_011_100_100);
        idle(12'b011_011_100_101);

        // Invalid load ignored, then overwrite of a filled slot
        cycle(1'b1, 3'b111, 2'd1, 1'b1, 1'b0, 12'b001_010_011_100);
        cycle(1'b1, 3'b110, 2'd1, 1'b1, 1'b0, 12'b001_010_110_100);
        cycle(1'b1, 3'b000, 2'd2, 1'b1, 1'b0, 12'b001_010_110_100);

        // Clear wins over a simultaneous load
        cycle(1'b1, 3'b101, 2'd3, 1'b1, 1'b1, 12'h000);
        idle(12'h000);

        // Refill, then asynchronous reset while loaded
        for (int k = 0; k < 4; k++) cycle(1'b1, 3'(k + 2), 2'(k), 1'b1, 1'b0, 12'h000);
        idle(12'hFFF);
        async_reset();
        cycle(1'b0, 3'd3, 2'd1, 1'b1, 1'b0, 12'h000);
        idle(12'h000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            p = model_pattern();
            g = p;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(1, 0) == 1) g[3*k +: 3] = 3'($urandom_range(7, 0));
            if ($urandom_range(60, 0) == 0) begin
                async_reset();
                cycle(1'b0, 3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)),
                      1'($urandom_range(1, 0)), 1'b0, g);
            end else begin
                cycle(1'b1, 3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)),
                      ($urandom_range(3, 0) != 0), ($urandom_range(30, 0) == 0), g);
            end
        end
        idle(12'h000);

        drained = 0;
        while (q.size() != 0 && drained < 5) begin
            @(negedge clock);
            drained++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_master_pattern.md
# load_master_pattern

Holds the secret four-shape master pattern for the Mastermind-style game and scores guesses against it. Shapes are written one slot at a time from the setup controls. `masterLoaded` tells the game controller when all four slots hold valid shapes. The combinational Znarly count (exact slot matches between `Guess` and the stored pattern) is reported by the `check_for_znarly` sub-module.

## Interface
- No parameters; all widths are fixed constants from the shared package.
- `clock` input 1: single rising-edge clock.
- `reset_L` input 1: asynchronous, active-low reset.
- `LoadShape` input 3: shape code to write.
- `ShapeLocation` input 2: slot index 0–3.
- `loadingShape` input 1: write strobe, sampled on the clock edge.
- `startGame` input 1: synchronous clear of pattern and loaded flags.
- `Guess` input 12: four 3-bit shapes, same packing as `masterPattern`.
- `masterPattern` output 12: stored pattern, registered.
- `masterLoaded` output 1: high when all four slots hold valid shapes, registered.
- `Znarly` output 4: unsigned count 0–4 of slots where `Guess` equals `masterPattern`, combinational.

## Operation
- Packing: slot k occupies bits [3k+2:3k]. Slot 0 is [2:0] and slot 3 is [11:9].
- Valid shapes are 3'b001 through 3'b110. Codes 3'b000 and 3'b111 are invalid.
- Each slot has a `filled` bit. `masterLoaded` is the AND of the four `filled` bits.
- On each rising edge, in priority order:
  1. `startGame` = 1: all slots ← 3'b000 and all `filled` ← 0. Any `loadingShape` in the same cycle is ignored.
  2. `loadingShape` = 1 and `LoadShape` valid: slot[`ShapeLocation`] ← `LoadShape` and its `filled` ← 1.
  3. Otherwise: hold.
- `loadingShape` = 1 with an invalid `LoadShape`: no state change.
- Writing a slot that is already filled overwrites it; `filled` stays 1.
- Loading continues to be accepted after `masterLoaded` = 1. There is no lock.
- `Znarly` = sum over k of (`Guess` slot k == `masterPattern` slot k).
  - Compare the full 3-bit fields; invalid codes compare like any other value.
  - Zero-extend each match bit to 4 bits before adding; the maximum is 4'd4.

## Timing
- Reset (`reset_L` = 0, asynchronous): `masterPattern` = 12'h000, all `filled` = 0, `masterLoaded` = 0.
  - `Znarly` then follows `Guess` against 0: `Guess` = 0 gives 4.
- Reset is released synchronously by the implementation's internal reset synchronizer, or the environment guarantees deassertion away from the clock edge.
- Reset asserted mid-load clears everything immediately; no partial state survives.
- Write latency is one cycle: a shape sampled at edge N is visible on `masterPattern` after edge N.
- `masterLoaded` rises after the edge that fills the last empty slot.
- `masterLoaded` falls after a `startGame` edge or an asynchronous reset.
- `Znarly` has zero cycles of latency from `Guess` or `masterPattern`. It settles within the same cycle, with no registers.
- No handshake: every qualified strobe is accepted in the cycle it is presented.

## Structure
- Shared package `mastermind_pkg`:
  - `SHAPE_W` = 3, `NUM_SLOTS` = 4, `PATTERN_W` = 12.
  - `shape_t` enum: `BLANK` = 0, `TRIANGLE` = 1, `CIRCLE` = 2, `DIAMOND` = 3, `ICECREAM` = 4, `DOLLAR` = 5, `STAR` = 6, `INVALID` = 7.
  - Helper function `is_valid_shape`.
- Sub-module `check_for_znarly`:
  - Inputs: `masterPattern`[11:0], `Guess`[11:0]. Output: `Znarly`[3:0].
  - Purely combinational; reusable by the game controller for guess scoring.
- Top-level contents: slot registers, `filled` flags, write decoder, and one instance of `check_for_znarly`.

## Test plan
- Reset, then load: `reset_L` low, then high. Load `LoadShape` = 001 at `ShapeLocation` = 00 for one edge → `masterPattern` = 12'b000_000_000_001, `masterLoaded` = 0.
- Fill all slots: load 100@0, 011@1, 010@2, 001@3 on consecutive edges → `masterPattern` = 12'b001_010_011_100, and `masterLoaded` = 1 exactly after the fourth edge.
- Znarly counts with `masterPattern` = 001_010_011_100:
  - `Guess` = 001010011100 → 4.
  - `Guess` = 011010011100 → 3.
  - `Guess` = 011011011100 → 2.
  - `Guess` = 011011100100 → 1.
  - `Guess` = 011011100101 → 0.
- Invalid and overwrite: load 111@1 → no change. Then load 110@1 → slot 1 = 110, `masterLoaded` unchanged.
- Clear priority: `startGame` = 1 and `loadingShape` = 1 on the same edge → `masterPattern` = 0, `masterLoaded` = 0.
- Async reset mid-load: assert `reset_L` = 0 between edges while `masterLoaded` = 1 → outputs clear immediately, without waiting for a clock edge.
